// File: rtl/bus_pkg.sv
// Shared widths, FSM encoding and defaults for the bus router and its decoder.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hdeadbeef;
    localparam logic [ADDR_W-1:0] IO_BASE_DEF  = 32'hffff0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bus_router_if.sv
// CPU-side native memory bus plus the fan-out slave channels and error status.
interface bus_router_if
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 8
);
    logic                         mem_valid;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [STRB_W-1:0]            mem_wstrb;
    logic                         mem_ready;
    logic [DATA_W-1:0]            mem_rdata;

    logic [NUM_SLAVES-1:0]        slv_valid;
    logic [ADDR_W-1:0]            slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [STRB_W-1:0]            slv_wstrb;
    logic [DATA_W*NUM_SLAVES-1:0] slv_rdata;
    logic [NUM_SLAVES-1:0]        slv_ready;

    logic                         bus_err;
    logic [ADDR_W-1:0]            err_addr;
    logic [15:0]                  err_count;

    // Environment side: CPU requests and slave responses.
    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, slv_rdata, slv_ready,
        input  mem_ready, mem_rdata, slv_valid, slv_addr, slv_wdata, slv_wstrb,
        input  bus_err, err_addr, err_count
    );

    // Router side.
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, slv_rdata, slv_ready,
        output mem_ready, mem_rdata, slv_valid, slv_addr, slv_wdata, slv_wstrb,
        output bus_err, err_addr, err_count
    );
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decode: I/O window region index or default slave,
// flagging window regions that have no slave behind them.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int               NUM_SLAVES    = 8,
    parameter int               REGION_LSB    = 4,
    parameter logic [ADDR_W-1:0] IO_BASE      = IO_BASE_DEF,
    parameter int               DEFAULT_SLAVE = NUM_SLAVES - 1,
    localparam int              SEL_W         = $clog2(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [SEL_W-1:0]  target_o,
    output logic              unmapped_o
);
    localparam int WIN_LSB = REGION_LSB + SEL_W;

    logic             in_win;
    logic [SEL_W-1:0] idx;
    logic             idx_oob;
    logic             unused_low_bits;

    assign in_win          = (addr_i[ADDR_W-1:WIN_LSB] == IO_BASE[ADDR_W-1:WIN_LSB]);
    assign idx             = addr_i[REGION_LSB +: SEL_W];
    assign unused_low_bits = ^addr_i[REGION_LSB-1:0];

    // Only a non-power-of-two slave count leaves holes in the window.
    generate
        if (NUM_SLAVES == (1 << SEL_W)) begin : g_full
            assign idx_oob = 1'b0;
        end else begin : g_holes
            assign idx_oob = ({1'b0, idx} >= (SEL_W+1)'(NUM_SLAVES));
        end
    endgenerate

    assign target_o   = in_win ? idx : SEL_W'(DEFAULT_SLAVE);
    assign unmapped_o = in_win && idx_oob;

endmodule

// File: rtl/bus_router.sv
// Single-outstanding native-bus router: one-hot slave fan-out, registered
// response, bus-error reply on unmapped or timed-out accesses.
module bus_router
    import bus_pkg::*;
#(
    parameter int                NUM_SLAVES    = 8,
    parameter int                REGION_LSB    = 4,
    parameter logic [ADDR_W-1:0] IO_BASE       = IO_BASE_DEF,
    parameter int                DEFAULT_SLAVE = NUM_SLAVES - 1,
    parameter int                TIMEOUT       = 255,
    parameter logic [DATA_W-1:0] ERR_DATA      = ERR_DATA_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    bus_router_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] slv_valid_q, slv_valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [SEL_W-1:0]      target_q, target_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [SEL_W-1:0]      dec_target;
    logic                  dec_unmapped;
    logic [DATA_W-1:0]     rdata_arr [NUM_SLAVES];
    logic [DATA_W-1:0]     sel_rdata;
    logic                  sel_ready;

    bus_addr_decode #(
        .NUM_SLAVES    (NUM_SLAVES),
        .REGION_LSB    (REGION_LSB),
        .IO_BASE       (IO_BASE),
        .DEFAULT_SLAVE (DEFAULT_SLAVE)
    ) u_decode (
        .addr_i     (bus.mem_addr),
        .target_o   (dec_target),
        .unmapped_o (dec_unmapped)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
            assign rdata_arr[gi] = bus.slv_rdata[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // Only the latched target's channel is ever observed.
    assign sel_rdata = rdata_arr[target_q];
    assign sel_ready = bus.slv_ready[target_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            slv_valid_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            target_q    <= '0;
            timer_q     <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            slv_valid_q <= slv_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slv_valid_d = slv_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        target_d    = target_q;
        timer_d     = timer_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid && !mem_ready_q) begin
                    addr_d   = bus.mem_addr;
                    wdata_d  = bus.mem_wdata;
                    wstrb_d  = bus.mem_wstrb;
                    target_d = dec_target;
                    if (dec_unmapped) begin
                        state_d = ST_ERR;
                    end else begin
                        slv_valid_d = NUM_SLAVES'(1) << dec_target;
                        timer_d     = '0;
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Ready takes priority over a timeout expiring in the same cycle.
                if (sel_ready) begin
                    mem_rdata_d = sel_rdata;
                    slv_valid_d = '0;
                    mem_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end else if ((TIMEOUT != 0) && (timer_q == TMO_LAST)) begin
                    slv_valid_d = '0;
                    state_d     = ST_ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ERR: begin
                mem_rdata_d = ERR_DATA;
                mem_ready_d = 1'b1;
                bus_err_d   = 1'b1;
                err_addr_d  = addr_q;
                err_count_d = sat_inc16(err_count_q);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.slv_valid = slv_valid_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wstrb = wstrb_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: an 8-slave instance for the main paths and a
// 6-slave instance for the unmapped window hole.
module tb_bus_router;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bus_router_if #(.NUM_SLAVES(8)) bif ();
    bus_router_if #(.NUM_SLAVES(6)) bif6 ();

    bus_router #(.NUM_SLAVES(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    bus_router #(.NUM_SLAVES(6)) dut6 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bif.mem_valid = 1'b1;
        bif.mem_addr  = a;
        bif.mem_wdata = d;
        bif.mem_wstrb = s;
    endtask

    // Called in the RESP cycle: CPU keeps valid through RESP, drops it after.
    task automatic finish_txn(input string tag);
        bif.slv_ready = '0;
        tick();
        bif.mem_valid = 1'b0;
        chk({tag, "_ready_clr"}, 32'(bif.mem_ready), 32'd0);
        chk({tag, "_no_retrig"}, 32'(bif.slv_valid), 32'd0);
        tick();
    endtask

    initial begin
        int fall;
        int resp;

        bif.mem_valid  = 1'b0;
        bif.mem_addr   = '0;
        bif.mem_wdata  = '0;
        bif.mem_wstrb  = '0;
        bif.slv_rdata  = '0;
        bif.slv_ready  = '0;
        bif6.mem_valid = 1'b0;
        bif6.mem_addr  = '0;
        bif6.mem_wdata = '0;
        bif6.mem_wstrb = '0;
        bif6.slv_rdata = '0;
        bif6.slv_ready = '0;

        repeat (3) tick();
        chk("rst_ready", 32'(bif.mem_ready), 32'd0);
        chk("rst_valid", 32'(bif.slv_valid), 32'd0);
        chk("rst_rdata", bif.mem_rdata, 32'd0);
        chk("rst_errcnt", 32'(bif.err_count), 32'd0);
        resetn = 1'b1;
        tick();

        // 1: read slave 3, ready one cycle after slv_valid
        req(32'hffff0034, 32'h0, 4'h0);
        tick();
        chk("t1_valid", 32'(bif.slv_valid), 32'h08);
        bif.slv_rdata[32*3 +: 32] = 32'h12345678;
        tick();
        chk("t1_early", 32'(bif.mem_ready), 32'd0);
        bif.slv_ready = 8'h08;
        tick();
        chk("t1_ready", 32'(bif.mem_ready), 32'd1);
        chk("t1_rdata", bif.mem_rdata, 32'h12345678);
        chk("t1_err", 32'(bif.bus_err), 32'd0);
        finish_txn("t1");
        chk("t1_hold", bif.mem_rdata, 32'h12345678);
        $display("txn t1 read  ffff0034 -> rdata %h", bif.mem_rdata);

        // 2: write outside the window goes to default slave 7, minimum latency
        req(32'h00001000, 32'ha5a55a5a, 4'hf);
        tick();
        chk("t2_valid", 32'(bif.slv_valid), 32'h80);
        chk("t2_addr", bif.slv_addr, 32'h00001000);
        chk("t2_wdata", bif.slv_wdata, 32'ha5a55a5a);
        chk("t2_wstrb", 32'(bif.slv_wstrb), 32'hf);
        chk("t2_early", 32'(bif.mem_ready), 32'd0);
        bif.slv_rdata[32*7 +: 32] = 32'h0badf00d;
        bif.slv_ready = 8'h80;
        tick();
        chk("t2_ready", 32'(bif.mem_ready), 32'd1);
        chk("t2_rdata", bif.mem_rdata, 32'h0badf00d);
        chk("t2_err", 32'(bif.bus_err), 32'd0);
        finish_txn("t2");
        $display("txn t2 write 00001000 -> slave 7 rdata %h", bif.mem_rdata);

        // 3: slave 5 never ready, every other slave ready (ignored) -> timeout
        req(32'hffff0050, 32'h0, 4'h0);
        bif.slv_ready = 8'hdf;
        fall = 0;
        resp = 0;
        for (int c = 1; c <= 300 && resp == 0; c++) begin
            tick();
            if (fall == 0 && bif.slv_valid == '0) fall = c;
            if (bif.mem_ready) resp = c;
        end
        chk("t3_fall", 32'(fall), 32'd256);
        chk("t3_resp", 32'(resp), 32'd257);
        chk("t3_rdata", bif.mem_rdata, 32'hdeadbeef);
        chk("t3_err", 32'(bif.bus_err), 32'd1);
        chk("t3_erraddr", bif.err_addr, 32'hffff0050);
        chk("t3_errcnt", 32'(bif.err_count), 32'd1);
        finish_txn("t3");
        $display("txn t3 read  ffff0050 -> timeout at cycle %0d", resp);

        // 4: 6-slave instance, region 6 is a hole
        bif6.mem_valid = 1'b1;
        bif6.mem_addr  = 32'hffff0060;
        tick();
        chk("t4_valid", 32'(bif6.slv_valid), 32'd0);
        chk("t4_early", 32'(bif6.mem_ready), 32'd0);
        tick();
        chk("t4_ready", 32'(bif6.mem_ready), 32'd1);
        chk("t4_err", 32'(bif6.bus_err), 32'd1);
        chk("t4_rdata", bif6.mem_rdata, 32'hdeadbeef);
        chk("t4_errcnt", 32'(bif6.err_count), 32'd1);
        chk("t4_erraddr", bif6.err_addr, 32'hffff0060);
        tick();
        bif6.mem_valid = 1'b0;
        chk("t4_err_clr", 32'(bif6.bus_err), 32'd0);
        $display("txn t4 read  ffff0060 (6 slaves) -> unmapped, err_count %0d", bif6.err_count);

        // 5: ready on the very cycle the timeout would fire
        req(32'hffff0020, 32'h0, 4'h0);
        resp = 0;
        for (int c = 1; c <= 300 && resp == 0; c++) begin
            tick();
            if (c == 255) begin
                bif.slv_rdata[32*2 +: 32] = 32'hcafe0002;
                bif.slv_ready = 8'h04;
            end
            if (bif.mem_ready) resp = c;
        end
        chk("t5_resp", 32'(resp), 32'd256);
        chk("t5_err", 32'(bif.bus_err), 32'd0);
        chk("t5_rdata", bif.mem_rdata, 32'hcafe0002);
        chk("t5_errcnt", 32'(bif.err_count), 32'd1);
        finish_txn("t5");
        $display("txn t5 read  ffff0020 -> ready at timeout edge, rdata %h", bif.mem_rdata);

        // 6: asynchronous reset in the middle of WAIT
        req(32'hffff0010, 32'h0, 4'h0);
        tick();
        chk("t6_valid", 32'(bif.slv_valid), 32'h02);
        tick();
        tick();
        #2;
        resetn = 1'b0;
        bif.mem_valid = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bif.slv_valid), 32'd0);
        chk("t6_rst_ready", 32'(bif.mem_ready), 32'd0);
        chk("t6_rst_errcnt", 32'(bif.err_count), 32'd0);
        chk("t6_rst_rdata", bif.mem_rdata, 32'd0);
        chk("t6_rst_addr", bif.slv_addr, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        req(32'hffff0030, 32'h0, 4'h0);
        tick();
        chk("t6_post_valid", 32'(bif.slv_valid), 32'h08);
        bif.slv_rdata[32*3 +: 32] = 32'h600dcafe;
        bif.slv_ready = 8'h08;
        tick();
        chk("t6_post_ready", 32'(bif.mem_ready), 32'd1);
        chk("t6_post_rdata", bif.mem_rdata, 32'h600dcafe);
        finish_txn("t6");
        $display("txn t6 reset mid-WAIT, then read ffff0030 -> rdata %h", bif.mem_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
